// File: rtl/data_mem_responder_if.sv
// Request/response bus between the CPU MEM stage (master) and the
// data-memory responder (slave). Both channels use valid/ready handshakes.
interface data_mem_responder_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [31:0]          req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;
    logic [3:0]           req_be;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [BIT_WIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store at a time, serviced
// from internal word storage after LATENCY wait cycles.
// Optional macro DMEM_RANGE_CHECK_EN: byte addresses >= ENTRY_COUNT*4 fault
// instead of wrapping modulo ENTRY_COUNT.
module data_mem_responder #(
    parameter int BIT_WIDTH   = 32,
    parameter int ENTRY_COUNT = 32,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int         IDX_W = $clog2(ENTRY_COUNT);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]           be_q, be_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [BIT_WIDTH-1:0] mem_q [ENTRY_COUNT];

    logic                 acc_we_s;
    logic [31:0]          acc_addr_s;
    logic [BIT_WIDTH-1:0] acc_wdata_s;
    logic [3:0]           acc_be_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 err_s;
    logic                 enter_resp_s;
    logic                 wr_en_s;

    // Access operands: with zero latency the access runs on the accept edge,
    // so the live request is used in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we_s    = bus.req_we;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
            acc_be_s    = bus.req_be;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
            acc_be_s    = be_q;
        end
        idx_s = acc_addr_s[IDX_W+1:2];
`ifdef DMEM_RANGE_CHECK_EN
        err_s = (acc_addr_s[1:0] != 2'b00) ||
                (acc_addr_s >= 32'(ENTRY_COUNT * 4));
`else
        err_s = (acc_addr_s[1:0] != 2'b00);
`endif
    end

    // Next-state, request latch and registered-output next values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = LAT_C;
                    if (LAT_C == 4'd0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d      = ST_RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        if (enter_resp_s) begin
            rsp_err_d   = err_s;
            rsp_rdata_d = (err_s || acc_we_s) ? '0 : mem_q[idx_s];
        end else if (state_d == ST_IDLE) begin
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
        end else begin
            rsp_err_d   = rsp_err_q;
            rsp_rdata_d = rsp_rdata_q;
        end
        wr_en_s = enter_resp_s && acc_we_s && !err_s;
    end

    // Control/state registers; a reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= '0;
            be_q        <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Word storage with per-byte-lane writes on entry into RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRY_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be_s[b]) begin
                    mem_q[idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY=2 and LATENCY=0) share the
// stimulus; sel chooses which one sees req_valid and drives the observed
// outputs. A word-array model computes expected responses.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_mem [2][32];

    data_mem_responder_if #(.BIT_WIDTH(32)) bus2 ();
    data_mem_responder_if #(.BIT_WIDTH(32)) bus0 ();

    assign bus2.req_valid = req_valid & sel;
    assign bus0.req_valid = req_valid & ~sel;
    assign bus2.req_we = req_we;     assign bus0.req_we = req_we;
    assign bus2.req_addr = req_addr; assign bus0.req_addr = req_addr;
    assign bus2.req_wdata = req_wdata; assign bus0.req_wdata = req_wdata;
    assign bus2.req_be = req_be;     assign bus0.req_be = req_be;
    assign bus2.rsp_ready = rsp_ready; assign bus0.rsp_ready = rsp_ready;

    wire        req_ready_s = sel ? bus2.req_ready : bus0.req_ready;
    wire        rsp_valid_s = sel ? bus2.rsp_valid : bus0.rsp_valid;
    wire [31:0] rsp_rdata_s = sel ? bus2.rsp_rdata : bus0.rsp_rdata;
    wire        rsp_err_s   = sel ? bus2.rsp_err   : bus0.rsp_err;

    data_mem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    // Reference behaviour: aligned word array, byte-lane stores, faults.
    function automatic void model_access(input int d, input logic we,
            input logic [31:0] addr, input logic [31:0] wdata,
            input logic [3:0] be, output logic err, output logic [31:0] rdata);
        int idx;
        err = (addr % 4) != 0;
`ifdef DMEM_RANGE_CHECK_EN
        if (addr >= 32'd128) err = 1'b1;
`endif
        idx   = int'((addr / 4) % 32);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[d][idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rdata = model_mem[d][idx];
            end
        end
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) model_mem[d][i] = 32'd0;
    endtask

    // One full transaction on the selected DUT with latency, stability and
    // handshake checks; rsp_ready is held low for 'hold' response cycles.
    task automatic txn(input logic we, input logic [31:0] addr,
            input logic [31:0] wdata, input logic [3:0] be, input int hold,
            output logic [31:0] got_rdata, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          n;
        int          exp_lat;
        exp_lat = sel ? 3 : 1;
        model_access(sel ? 1 : 0, we, addr, wdata, be, exp_err, exp_rdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_be = be; rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready_s && n < 50) begin @(negedge clk); n++; end
        tests++;
        if (!req_ready_s) begin
            fails++; $display("FAIL accept_timeout addr=%h", addr);
            req_valid = 1'b0; got_rdata = 32'd0; got_err = 1'b0; return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid_s && n < 40) begin @(posedge clk); #1; n++; end
        tests++;
        if (n !== exp_lat) begin
            fails++; $display("FAIL latency got=%0d exp=%0d", n, exp_lat);
        end
        got_rdata = rsp_rdata_s; got_err = rsp_err_s;
        tests++;
        if (rsp_err_s !== exp_err || rsp_rdata_s !== exp_rdata) begin
            fails++;
            $display("FAIL rsp addr=%h we=%b got err=%b data=%h exp err=%b data=%h",
                     addr, we, rsp_err_s, rsp_rdata_s, exp_err, exp_rdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid_s !== 1'b1 || rsp_rdata_s !== exp_rdata ||
                rsp_err_s !== exp_err || req_ready_s !== 1'b0) begin
                fails++;
                $display("FAIL hold_stable cyc=%0d got v=%b d=%h e=%b rr=%b exp v=1 d=%h e=%b rr=0",
                         i, rsp_valid_s, rsp_rdata_s, rsp_err_s, req_ready_s, exp_rdata, exp_err);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1 ||
            rsp_rdata_s !== 32'd0 || rsp_err_s !== 1'b0) begin
            fails++;
            $display("FAIL handshake got v=%b rr=%b d=%h e=%b exp v=0 rr=1 d=0 e=0",
                     rsp_valid_s, req_ready_s, rsp_rdata_s, rsp_err_s);
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0; sel = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus2.req_ready !== 1'b1 || bus2.rsp_valid !== 1'b0 ||
            bus2.rsp_rdata !== 32'd0 || bus2.rsp_err !== 1'b0 ||
            bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got rr=%b v=%b d=%h e=%b rr0=%b v0=%b exp 1 0 0 0 1 0",
                     bus2.req_ready, bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err,
                     bus0.req_ready, bus0.rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d;
        logic        e;
        sel = 1'b1;
        txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, d, e);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 5, d, e);
        tests++;
        if (d !== 32'hDEADBEEF) begin
            fails++; $display("FAIL load_full got=%h exp=deadbeef", d);
        end
        txn(1'b1, 32'h8, 32'h00001234, 4'b0011, 0, d, e);
        txn(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 1, d, e);
        txn(1'b0, 32'h8, 32'h0, 4'h0, 0, d, e);
        tests++;
        if (d !== 32'hDEAD1234) begin
            fails++; $display("FAIL load_partial got=%h exp=dead1234", d);
        end
        txn(1'b0, 32'h6, 32'h0, 4'h0, 0, d, e);
        tests++;
        if (e !== 1'b1 || d !== 32'd0) begin
            fails++; $display("FAIL misaligned_load got e=%b d=%h exp e=1 d=0", e, d);
        end
        txn(1'b1, 32'h6, 32'h55555555, 4'hF, 0, d, e);
        txn(1'b1, 32'h0, 32'hA5A5_0F0F, 4'hF, 0, d, e);
        txn(1'b0, 32'h80, 32'h0, 4'h0, 0, d, e);
        tests++;
`ifdef DMEM_RANGE_CHECK_EN
        if (e !== 1'b1 || d !== 32'd0) begin
            fails++; $display("FAIL range_load got e=%b d=%h exp e=1 d=0", e, d);
        end
`else
        if (e !== 1'b0 || d !== 32'hA5A5_0F0F) begin
            fails++; $display("FAIL wrap_load got e=%b d=%h exp e=0 d=a5a50f0f", e, d);
        end
`endif
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14;
        req_wdata = 32'hCAFE_F00D; req_be = 4'hF; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_we = 1'b0; req_wdata = 32'h0;
        tests++;
        if (rsp_valid_s !== 1'b1 || rsp_err_s !== 1'b0 || rsp_rdata_s !== 32'd0 ||
            req_ready_s !== 1'b0) begin
            fails++; $display("FAIL b2b_store_rsp got v=%b e=%b d=%h rr=%b exp 1 0 0 0",
                              rsp_valid_s, rsp_err_s, rsp_rdata_s, req_ready_s);
        end
        @(posedge clk); #1;
        tests++;
        if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin
            fails++; $display("FAIL b2b_gap got v=%b rr=%b exp v=0 rr=1", rsp_valid_s, req_ready_s);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if (rsp_valid_s !== 1'b1 || rsp_rdata_s !== 32'hCAFE_F00D || rsp_err_s !== 1'b0) begin
            fails++; $display("FAIL b2b_load_rsp got v=%b d=%h e=%b exp v=1 d=cafef00d e=0",
                              rsp_valid_s, rsp_rdata_s, rsp_err_s);
        end
        @(posedge clk); #1;
        tests++;
        if (rsp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin
            fails++; $display("FAIL b2b_end got v=%b rr=%b exp v=0 rr=1", rsp_valid_s, req_ready_s);
        end
        rsp_ready = 1'b0;
        model_mem[0][5] = 32'hCAFE_F00D;
    endtask

    task automatic test_random();
        logic [31:0] d, a;
        logic        e;
        int          kind;
        for (int i = 0; i < 60; i++) begin
            sel  = (i % 2 == 0);
            kind = int'($urandom_range(0, 3));
            a    = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            if (kind == 2) a = a + 32'($urandom_range(1, 3));
            if (kind == 3) a = 32'h80 + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), d, e);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d;
        logic        e;
        sel = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10;
        req_wdata = 32'h1234_5678; req_be = 4'hF; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin @(negedge clk); rst = 1'b1; end
            @(posedge clk); #1;
            tests++;
            if (rsp_valid_s !== 1'b0) begin
                fails++; $display("FAIL reset_drop cyc=%0d got v=%b exp v=0", i, rsp_valid_s);
            end
        end
        rsp_ready = 1'b0;
        clear_model();
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, d, e);
        tests++;
        if (d !== 32'd0) begin
            fails++; $display("FAIL reset_mem got=%h exp=0", d);
        end
        txn(1'b0, 32'h8, 32'h0, 4'h0, 0, d, e);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
